// File: rtl/fp_div_arbiter_pkg.sv
// fp_div_arbiter_pkg: fixed-point format and divider-sharing tag types
package fp_div_arbiter_pkg;
  localparam int FP_QINT = 16;
  localparam int FP_QFRAC = 16;
  localparam int FP_WIDTH = FP_QINT + FP_QFRAC;
  localparam int FP_DIV_LATENCY = 16;
  localparam int FP_DIV_MAX_REQ = 4;
  localparam int FP_DIV_TAG_W = $clog2(FP_DIV_MAX_REQ);
  typedef struct packed {
    logic v;
    logic [FP_DIV_TAG_W-1:0] tag;
  } div_tag_t;
endpackage

// File: rtl/fp_div_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first request at/after the pointer
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic [$clog2(N)-1:0] nxt_ptr_o,
  output logic                 any_o
);
  localparam int PW = $clog2(N);
  // Scan from farthest to nearest so the nearest requester wins the last write
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
        idx_o = PW'((int'(ptr_i) + k) % N);
        any_o = 1'b1;
      end
    end
    nxt_ptr_o = any_o ? PW'((int'(idx_o) + 1) % N) : ptr_i;
  end
endmodule

// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: round-robin sharing of one pipelined Q16.16 divider,
// with a tag pipe that routes each quotient back to its requester.
module fp_div_arbiter
  import fp_div_arbiter_pkg::*;
#(
  parameter int N_REQ   = FP_DIV_MAX_REQ,
  parameter int WIDTH   = FP_WIDTH,
  parameter int LATENCY = FP_DIV_LATENCY
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_num,
  input  logic [N_REQ*WIDTH-1:0] req_den,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]       resp_q,
  output logic                   div_in_valid,
  output logic [WIDTH-1:0]       div_num,
  output logic [WIDTH-1:0]       div_den,
  input  logic                   div_out_valid,
  input  logic [WIDTH-1:0]       div_q,
  output logic                   err_sync
);
  localparam int PW = $clog2(N_REQ);
  logic [N_REQ-1:0] gnt;
  logic [PW-1:0] gnt_idx, ptr_q, ptr_d;
  logic gnt_any;
  logic in_valid_q;
  logic [WIDTH-1:0] num_q, den_q;
  logic [FP_DIV_TAG_W-1:0] tag_q;
  div_tag_t pipe_q [LATENCY];
  div_tag_t tag_out;
  logic [N_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_q_q;
  logic err_q;
  // Gating with rst_n keeps req_ready low while reset is held
  rr_arbiter #(.N(N_REQ)) u_rr (
    .req_i     (req_valid & {N_REQ{rst_n}}),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .idx_o     (gnt_idx),
    .nxt_ptr_o (ptr_d),
    .any_o     (gnt_any)
  );
  always_comb begin
    tag_out = pipe_q[LATENCY-1];
    resp_valid_d = tag_out.v ? N_REQ'(1) << tag_out.tag : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      in_valid_q <= 1'b0;
      num_q <= '0;
      den_q <= '0;
      tag_q <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
      resp_valid_q <= '0;
      resp_q_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      in_valid_q <= gnt_any;
      if (gnt_any) begin
        num_q <= req_num[gnt_idx*WIDTH +: WIDTH];
        den_q <= req_den[gnt_idx*WIDTH +: WIDTH];
        tag_q <= FP_DIV_TAG_W'(gnt_idx);
      end
      pipe_q[0] <= '{v: in_valid_q, tag: tag_q};
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      resp_valid_q <= resp_valid_d;
      if (tag_out.v) resp_q_q <= div_q;
      err_q <= err_q | (div_out_valid != tag_out.v);
    end
  end
  assign req_ready = gnt;
  assign div_in_valid = in_valid_q;
  assign div_num = num_q;
  assign div_den = den_q;
  assign resp_valid = resp_valid_q;
  assign resp_q = resp_q_q;
  assign err_sync = err_q;
endmodule

// File: tb/tb_fp_div_arbiter.sv
// tb_fp_div_arbiter: random and directed stimulus against a round-robin/scoreboard
// reference model, with a behavioural Q16.16 divider attached to the arbiter.
module tb_fp_div_arbiter;
  localparam int N = 4, W = 32, L = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, resp_valid;
  logic [N*W-1:0] req_num = '0, req_den = '0;
  logic [W-1:0] resp_q, div_num, div_den, div_q;
  logic div_in_valid, div_out_valid, err_sync;
  logic inj = 1'b0, rnd = 1'b0, exp_err = 1'b0;
  logic [N-1:0] hs = '0;
  int n_chk = 0, n_err = 0, cyc = 0, mptr = 0, t0 = -1, r0_cyc = -1;
  logic [W-1:0] r0_q = '0;
  int want [N], gcnt [N], rcnt [N];
  typedef struct {int t; int i; logic [W-1:0] q;} exp_t;
  exp_t sb [$];
  logic [L-1:0] dv;
  logic [W-1:0] dq [L];
  fp_div_arbiter #(.N_REQ(N), .WIDTH(W), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_num(req_num), .req_den(req_den), .resp_valid(resp_valid), .resp_q(resp_q),
    .div_in_valid(div_in_valid), .div_num(div_num), .div_den(div_den),
    .div_out_valid(div_out_valid), .div_q(div_q), .err_sync(err_sync)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic logic [W-1:0] fdiv(input logic [W-1:0] n, input logic [W-1:0] d);
    longint sn, sd;
    sn = longint'($signed(n)) * 65536;
    sd = longint'($signed(d));
    return d == '0 ? '0 : W'(sn / sd);
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv <= '0;
      for (int k = 0; k < L; k++) dq[k] <= '0;
    end else begin
      dv <= {dv[L-2:0], div_in_valid};
      dq[0] <= fdiv(div_num, div_den);
      for (int k = 1; k < L; k++) dq[k] <= dq[k-1];
    end
  end
  assign div_out_valid = dv[L-1] | inj;
  assign div_q = dq[L-1];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    logic [N-1:0] g, erv;
    logic [W-1:0] eq;
    int j;
    if (rst_n) begin
      g = '0;
      for (int k = 0; k < N; k++) begin
        j = (mptr + k) % N;
        if (g == '0 && req_valid[j]) g[j] = 1'b1;
      end
      check("req_ready", 32'(req_ready), 32'(g));
      hs = g;
      for (int i = 0; i < N; i++)
        if (g[i]) begin
          sb.push_back('{cyc + L + 2, i, fdiv(req_num[i*W +: W], req_den[i*W +: W])});
          mptr = (i + 1) % N;
          gcnt[i]++;
          if (i == 0) t0 = cyc;
        end
      erv = '0;
      eq = '0;
      if (sb.size() != 0 && sb[0].t == cyc) begin
        erv[sb[0].i] = 1'b1;
        eq = sb[0].q;
        rcnt[sb[0].i]++;
        sb.delete(0);
      end
      check("resp_valid", 32'(resp_valid), 32'(erv));
      if (erv != '0) check("resp_q", resp_q, eq);
      if (resp_valid[0]) begin
        r0_cyc = cyc;
        r0_q = resp_q;
      end
      check("err_sync", 32'(err_sync), 32'(exp_err));
      if (inj) exp_err = 1'b1;
    end
  end
  task automatic new_op(input int i);
    logic [W-1:0] d;
    d = $urandom;
    if (d == '0) d = 32'h0001_0000;
    req_num[i*W +: W] = $urandom;
    req_den[i*W +: W] = d;
  endtask
  task automatic apply();
    for (int i = 0; i < N; i++) req_valid[i] = want[i] != 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        if (want[i] > 0) want[i]--;
        new_op(i);
      end
      if (!rnd) req_valid[i] = want[i] != 0;
    end
    if (rnd) req_valid = N'($urandom);
  endtask
  task automatic idle();
    for (int i = 0; i < N; i++) want[i] = 0;
    rnd = 1'b0;
    apply();
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      step();
      n++;
    end
    check("drain_empty", 32'(sb.size()), 0);
  endtask
  task automatic chk_rst();
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp_q", resp_q, 0);
    check("rst_div_in_valid", 32'(div_in_valid), 0);
    check("rst_div_num", div_num, 0);
    check("rst_div_den", div_den, 0);
    check("rst_err_sync", 32'(err_sync), 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < N; i++) begin
      want[i] = 0;
      gcnt[i] = 0;
      rcnt[i] = 0;
      new_op(i);
    end
    req_valid = '1;
    repeat (3) @(posedge clk);
    #1;
    chk_rst();
    req_valid = '0;
    rst_n = 1'b1;
    // Only req2/req3 requesting from pointer 0
    want[2] = -1;
    want[3] = -1;
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    apply();
    repeat (6) step();
    check("t3_gcnt0", 32'(gcnt[0]), 0);
    check("t3_gcnt1", 32'(gcnt[1]), 0);
    check("t3_gcnt2", 32'(gcnt[2]), 3);
    check("t3_gcnt3", 32'(gcnt[3]), 3);
    idle();
    drain();
    // Single 6.0 / 2.0 from req0
    req_num[0 +: W] = 32'h0006_0000;
    req_den[0 +: W] = 32'h0002_0000;
    want[0] = 1;
    r0_cyc = -1;
    apply();
    repeat (22) step();
    check("t1_latency", 32'(r0_cyc - t0), 18);
    check("t1_quotient", r0_q, 32'h0003_0000);
    idle();
    drain();
    // All four continuous: fair share over 40 cycles
    for (int i = 0; i < N; i++) begin
      want[i] = -1;
      gcnt[i] = 0;
    end
    apply();
    repeat (40) step();
    for (int i = 0; i < N; i++) check("t2_fair_share", 32'(gcnt[i]), 10);
    idle();
    drain();
    // Back-to-back from req1
    want[1] = 20;
    rcnt[1] = 0;
    apply();
    for (int n = 0; n < 40 && want[1] != 0; n++) step();
    idle();
    drain();
    check("t4_resp_count", 32'(rcnt[1]), 20);
    // Random valid patterns, including withdrawals
    rnd = 1'b1;
    repeat (200) step();
    idle();
    drain();
    // Reset with ops in flight
    for (int i = 0; i < N; i++) want[i] = -1;
    apply();
    repeat (10) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_rst();
    idle();
    sb.delete();
    mptr = 0;
    exp_err = 1'b0;
    hs = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (25) step();
    check("t5_err_after_reset", 32'(err_sync), 0);
    // Spurious divider strobe with an empty tag pipe
    inj = 1'b1;
    step();
    inj = 1'b0;
    repeat (5) step();
    check("t6_err_sticky", 32'(err_sync), 1);
    check("t6_no_resp", 32'(resp_valid), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
